// File: rtl/mem_bus_pkg.sv
// Shared definitions for the two-master memory bus arbiter.
//   state_t    : arbiter FSM encoding (IDLE/BUS/ACK)
//   RW_*       : transfer direction, same polarity as the CPU rw line
//   M_*        : master indices (CPU core, loader/debug port)
//   cnt_width  : wait-counter width for a given timeout
package mem_bus_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUS  = 2'd1,
        ACK  = 2'd2
    } state_t;

    localparam logic RW_READ  = 1'b1;
    localparam logic RW_WRITE = 1'b0;

    localparam logic M_CPU    = 1'b0;
    localparam logic M_LOADER = 1'b1;

    // ceil(log2(t+1)) bits; a disabled timeout (t=0) still gets one bit
    // so the counter never collapses to zero width.
    function automatic int cnt_width(input int t);
        return (t > 0) ? $clog2(t + 1) : 1;
    endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Bus bundle between the two masters, the arbiter and the memory port.
//   m0_* / m1_* : per-master req/ack handshake, address, data, lock, err
//   mem_*       : shared memory port
//   owner, busy : arbiter status
// Modports: slave = arbiter view, master = environment (masters + memory).
interface mem_arbiter_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32
);
    logic              m0_req,   m1_req;
    logic              m0_rw,    m1_rw;
    logic [ADDR_W-1:0] m0_addr,  m1_addr;
    logic [DATA_W-1:0] m0_wdata, m1_wdata;
    logic              m0_lock,  m1_lock;
    logic              m0_ack,   m1_ack;
    logic              m0_err,   m1_err;
    logic [DATA_W-1:0] m0_rdata, m1_rdata;

    logic              mem_valid;
    logic              mem_rw;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_ready;

    logic              owner;
    logic              busy;

    modport slave (
        input  m0_req, m1_req, m0_rw, m1_rw, m0_addr, m1_addr,
               m0_wdata, m1_wdata, m0_lock, m1_lock, mem_rdata, mem_ready,
        output m0_ack, m1_ack, m0_err, m1_err, m0_rdata, m1_rdata,
               mem_valid, mem_rw, mem_addr, mem_wdata, owner, busy
    );

    modport master (
        output m0_req, m1_req, m0_rw, m1_rw, m0_addr, m1_addr,
               m0_wdata, m1_wdata, m0_lock, m1_lock, mem_rdata, mem_ready,
        input  m0_ack, m1_ack, m0_err, m1_err, m0_rdata, m1_rdata,
               mem_valid, mem_rw, mem_addr, mem_wdata, owner, busy
    );
endinterface

// File: rtl/rr_pick2.sv
// Combinational 2-way round-robin pick.
//   req0, req1 : pending requests
//   prio_last  : master that must yield on a tie
//   grant      : chosen master index (meaningful only when any=1)
//   any        : at least one request pending
module rr_pick2
    import mem_bus_pkg::*;
(
    input  logic req0,
    input  logic req1,
    input  logic prio_last,
    output logic grant,
    output logic any
);
    assign any   = req0 | req1;
    assign grant = (req0 & req1) ? ((prio_last == M_CPU) ? M_LOADER : M_CPU)
                                 : (req1 ? M_LOADER : M_CPU);
endmodule

// File: rtl/mem_arbiter.sv
// Two-master memory arbiter: CPU core (m0) and loader/debug port (m1)
// share one memory port. Round-robin grant with per-master lock, latched
// request presented to memory, bounded wait for mem_ready.
//   clock, reset : system clock, synchronous active-high reset
//   bus (slave)  : master handshakes, memory port, owner/busy status
module mem_arbiter
    import mem_bus_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 32,
    parameter int TIMEOUT = 16
) (
    input  logic          clock,
    input  logic          reset,
    mem_arbiter_if.slave  bus
);
    localparam int CNT_W = cnt_width(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    state_t                  state;
    logic                    owner_q;
    logic                    prio_last;
    logic                    rw_q;
    logic [ADDR_W-1:0]       addr_q;
    logic [DATA_W-1:0]       wdata_q;
    logic [CNT_W-1:0]        cnt;
    logic [1:0]              ack_q;
    logic [1:0]              err_q;
    logic [1:0][DATA_W-1:0]  rdata_q;

    logic [1:0] lock;
    logic       grant;
    logic       any;

    assign lock = {bus.m1_lock, bus.m0_lock};

    rr_pick2 u_pick (
        .req0      (bus.m0_req),
        .req1      (bus.m1_req),
        .prio_last (prio_last),
        .grant     (grant),
        .any       (any)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= IDLE;
            owner_q   <= M_CPU;
            prio_last <= M_LOADER;
            rw_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            cnt       <= '0;
            ack_q     <= '0;
            err_q     <= '0;
            rdata_q   <= '0;
        end else begin
            // ack/err are single-cycle pulses raised only on entry to ACK
            ack_q <= '0;
            err_q <= '0;
            case (state)
                IDLE: begin
                    if (any) begin
                        owner_q <= grant;
                        rw_q    <= grant ? bus.m1_rw    : bus.m0_rw;
                        addr_q  <= grant ? bus.m1_addr  : bus.m0_addr;
                        wdata_q <= grant ? bus.m1_wdata : bus.m0_wdata;
                        cnt     <= '0;
                        state   <= BUS;
                    end
                end
                BUS: begin
                    if (bus.mem_ready) begin
                        if (rw_q == RW_READ)
                            rdata_q[owner_q] <= bus.mem_rdata;
                        ack_q[owner_q] <= 1'b1;
                        state          <= ACK;
                    end else if (TIMEOUT != 0 && cnt == CNT_LAST) begin
                        if (rw_q == RW_READ)
                            rdata_q[owner_q] <= '0;
                        ack_q[owner_q] <= 1'b1;
                        err_q[owner_q] <= 1'b1;
                        state          <= ACK;
                    end else if (cnt != '1) begin
                        cnt <= cnt + 1'b1;
                    end
                end
                ACK: begin
                    // A locked owner makes the other master the one that
                    // yields on the next tie, so the owner keeps the bus.
                    prio_last <= lock[owner_q] ? ~owner_q : owner_q;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.m0_ack    = ack_q[0];
    assign bus.m1_ack    = ack_q[1];
    assign bus.m0_err    = err_q[0];
    assign bus.m1_err    = err_q[1];
    assign bus.m0_rdata  = rdata_q[0];
    assign bus.m1_rdata  = rdata_q[1];
    assign bus.mem_valid = (state == BUS);
    assign bus.mem_rw    = rw_q;
    assign bus.mem_addr  = addr_q;
    assign bus.mem_wdata = wdata_q;
    assign bus.owner     = owner_q;
    assign bus.busy      = (state != IDLE);

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: directed transactions per master,
// expected memory requests and acks queued by the stimulus, checked by
// an independent monitor on the falling edge.
module tb_mem_arbiter;
    import mem_bus_pkg::*;

    localparam int DW = 32;
    localparam int AW = 32;
    localparam int TO = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    mem_arbiter_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();

    mem_arbiter #(.DATA_W(DW), .ADDR_W(AW), .TIMEOUT(TO)) dut (
        .clock (clk),
        .reset (rst),
        .bus   (bus.slave)
    );

    typedef struct packed {
        logic          rw;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        logic          lock;
    } txn_t;

    typedef struct packed {
        logic          m;
        logic          err;
        logic [DW-1:0] rdata;
        int            lat;
    } ack_t;

    typedef struct packed {
        logic          m;
        logic          rw;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        int            lat;
    } mreq_t;

    txn_t  q0[$];
    txn_t  q1[$];
    ack_t  ack_q[$];
    mreq_t mreq_q[$];

    int n_chk   = 0;
    int n_pass  = 0;
    int cyc     = 0;
    int launch0 = 0;
    int launch1 = 0;
    int mem_lat = 0;
    logic [DW-1:0] mem [logic [AW-1:0]];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    endtask

    // ---------------- stimulus helpers ----------------
    task automatic issue(input logic m, input logic rw, input logic [AW-1:0] a,
                         input logic [DW-1:0] d, input logic lk);
        txn_t t;
        t.rw = rw; t.addr = a; t.wdata = d; t.lock = lk;
        if (m) q1.push_back(t); else q0.push_back(t);
    endtask

    task automatic exp_mem(input logic m, input logic rw, input logic [AW-1:0] a,
                           input logic [DW-1:0] d, input int lat);
        mreq_t e;
        e.m = m; e.rw = rw; e.addr = a; e.wdata = d; e.lat = lat;
        mreq_q.push_back(e);
    endtask

    task automatic exp_ack(input logic m, input logic err, input logic [DW-1:0] rd, input int lat);
        ack_t e;
        e.m = m; e.err = err; e.rdata = rd; e.lat = lat;
        ack_q.push_back(e);
    endtask

    function automatic int qsize(input logic m);
        return m ? q1.size() : q0.size();
    endfunction

    task automatic present(input logic m, input txn_t t, input logic en);
        if (!m) begin
            bus.m0_req = en; bus.m0_rw = t.rw; bus.m0_addr = t.addr;
            bus.m0_wdata = t.wdata; bus.m0_lock = en & t.lock;
        end else begin
            bus.m1_req = en; bus.m1_rw = t.rw; bus.m1_addr = t.addr;
            bus.m1_wdata = t.wdata; bus.m1_lock = en & t.lock;
        end
    endtask

    task automatic launch(input logic m, output txn_t t);
        if (m) begin t = q1.pop_front(); launch1 = cyc; end
        else   begin t = q0.pop_front(); launch0 = cyc; end
        present(m, t, 1'b1);
    endtask

    // Master driver: holds req until ack, then either presents the next
    // queued transaction right after the ACK edge or drops req.
    task automatic run_drv(input logic m);
        txn_t t;
        logic have;
        have = 1'b0;
        t    = '0;
        present(m, t, 1'b0);
        forever begin
            @(negedge clk);
            if (!have) begin
                if (qsize(m) > 0) begin launch(m, t); have = 1'b1; end
            end else if (rst) begin
                have = 1'b0;
                present(m, t, 1'b0);
            end else if (m ? bus.m1_ack : bus.m0_ack) begin
                @(posedge clk); #1;
                if (qsize(m) > 0) launch(m, t);
                else begin have = 1'b0; present(m, t, 1'b0); end
            end
        end
    endtask

    initial run_drv(1'b0);
    initial run_drv(1'b1);

    // Memory model: ready after mem_lat wait cycles (never if negative).
    initial begin
        int w;
        w = 0;
        bus.mem_ready = 1'b0;
        bus.mem_rdata = '0;
        forever begin
            @(negedge clk);
            bus.mem_ready = 1'b0;
            if (bus.mem_valid && !rst) begin
                if (mem_lat >= 0 && w == mem_lat) begin
                    bus.mem_ready = 1'b1;
                    if (bus.mem_rw) bus.mem_rdata = mem.exists(bus.mem_addr) ? mem[bus.mem_addr] : '0;
                    else            mem[bus.mem_addr] = bus.mem_wdata;
                end
                w++;
            end else begin
                w = 0;
            end
        end
    end

    // ---------------- monitor / scoreboard ----------------
    initial begin
        logic          pv;
        logic [DW-1:0] pr0, pr1;
        int            last_ack;
        mreq_t         em;
        ack_t          ea;
        pv = 1'b0; pr0 = '0; pr1 = '0; last_ack = -10;
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (bus.mem_valid && !pv) begin
                    if (mreq_q.size() == 0) begin
                        n_chk++;
                        $display("FAIL mem_req: unexpected request addr %0h", bus.mem_addr);
                    end else begin
                        em = mreq_q.pop_front();
                        check("mem_rw",    bus.mem_rw,    em.rw);
                        check("mem_addr",  bus.mem_addr,  em.addr);
                        check("mem_wdata", bus.mem_wdata, em.wdata);
                        if (em.lat > 0)
                            check("mem_valid_lat", cyc - (em.m ? launch1 : launch0), em.lat);
                    end
                end
                if (bus.m0_ack || bus.m1_ack) begin
                    if (ack_q.size() == 0) begin
                        n_chk++;
                        $display("FAIL ack: unexpected ack m0=%0b m1=%0b", bus.m0_ack, bus.m1_ack);
                    end else begin
                        ea = ack_q.pop_front();
                        check("ack_who",    {bus.m0_ack, bus.m1_ack}, ea.m ? 2'b01 : 2'b10);
                        check("ack_rdata",  ea.m ? bus.m1_rdata : bus.m0_rdata, ea.rdata);
                        check("ack_err",    ea.m ? bus.m1_err : bus.m0_err, ea.err);
                        check("ack_owner",  bus.owner, ea.m);
                        check("ack_single", (cyc - last_ack) > 1, 1'b1);
                        if (ea.lat > 0)
                            check("ack_lat", cyc - (ea.m ? launch1 : launch0), ea.lat);
                    end
                    last_ack = cyc;
                end
                if (!bus.m0_ack) check("m0_rdata_hold", bus.m0_rdata, pr0);
                if (!bus.m1_ack) check("m1_rdata_hold", bus.m1_rdata, pr1);
            end
            pv  = bus.mem_valid;
            pr0 = bus.m0_rdata;
            pr1 = bus.m1_rdata;
        end
    end

    task automatic check_reset_state();
        check("rst_mem_valid", bus.mem_valid, 1'b0);
        check("rst_busy",      bus.busy,      1'b0);
        check("rst_owner",     bus.owner,     1'b0);
        check("rst_m0_ack",    bus.m0_ack,    1'b0);
        check("rst_m1_ack",    bus.m1_ack,    1'b0);
        check("rst_m0_err",    bus.m0_err,    1'b0);
        check("rst_m1_err",    bus.m1_err,    1'b0);
        check("rst_m0_rdata",  bus.m0_rdata,  '0);
        check("rst_m1_rdata",  bus.m1_rdata,  '0);
        check("rst_mem_addr",  bus.mem_addr,  '0);
    endtask

    task automatic do_reset();
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check_reset_state();
        @(posedge clk); #1 rst = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int i;
        for (i = 0; i < 300; i++) begin
            @(negedge clk);
            if (q0.size() == 0 && q1.size() == 0 && ack_q.size() == 0 &&
                mreq_q.size() == 0 && !bus.m0_req && !bus.m1_req) break;
        end
        if (i >= 300) begin
            n_chk++;
            $display("FAIL %s: timed out with %0d acks and %0d mem requests outstanding",
                     name, ack_q.size(), mreq_q.size());
            q0.delete(); q1.delete(); ack_q.delete(); mreq_q.delete();
        end
        @(negedge clk);
    endtask

    // ---------------- directed tests ----------------
    initial begin
        mem[32'h10] = 32'hDEAD_BEEF;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_reset_state();
        @(posedge clk); #1 rst = 1'b0;

        // single read, memory ready in first BUS cycle
        @(posedge clk); #1;
        exp_mem(0, RW_READ, 32'h10, 0, 1);
        exp_ack(0, 0, 32'hDEAD_BEEF, 2);
        issue(0, RW_READ, 32'h10, 0, 0);
        wait_idle("single_read");

        // simultaneous continuous writes after reset: m0, m1, m0, m1
        do_reset();
        @(posedge clk); #1;
        exp_mem(0, RW_WRITE, 32'h100, 32'h11, 1);
        exp_mem(1, RW_WRITE, 32'h200, 32'h33, 0);
        exp_mem(0, RW_WRITE, 32'h104, 32'h22, 0);
        exp_mem(1, RW_WRITE, 32'h204, 32'h44, 0);
        exp_ack(0, 0, 32'h0, 2);
        exp_ack(1, 0, 32'h0, 0);
        exp_ack(0, 0, 32'h0, 0);
        exp_ack(1, 0, 32'h0, 0);
        issue(0, RW_WRITE, 32'h100, 32'h11, 0);
        issue(0, RW_WRITE, 32'h104, 32'h22, 0);
        issue(1, RW_WRITE, 32'h200, 32'h33, 0);
        issue(1, RW_WRITE, 32'h204, 32'h44, 0);
        wait_idle("round_robin");

        // m1 lock keeps the bus across ties until lock drops
        @(posedge clk); #1;
        exp_mem(0, RW_READ,  32'h100, 0, 1);
        exp_mem(1, RW_READ,  32'h200, 0, 0);
        exp_mem(1, RW_READ,  32'h204, 0, 0);
        exp_mem(1, RW_WRITE, 32'h208, 32'h55, 0);
        exp_mem(0, RW_READ,  32'h104, 0, 0);
        exp_ack(0, 0, 32'h11, 2);
        exp_ack(1, 0, 32'h33, 0);
        exp_ack(1, 0, 32'h44, 0);
        exp_ack(1, 0, 32'h44, 0);
        exp_ack(0, 0, 32'h22, 0);
        issue(0, RW_READ,  32'h100, 0, 0);
        issue(0, RW_READ,  32'h104, 0, 0);
        issue(1, RW_READ,  32'h200, 0, 1);
        issue(1, RW_READ,  32'h204, 0, 1);
        issue(1, RW_WRITE, 32'h208, 32'h55, 0);
        wait_idle("lock");

        // timeout: no mem_ready
        mem_lat = -1;
        @(posedge clk); #1;
        exp_mem(1, RW_READ, 32'h20, 0, 1);
        exp_ack(1, 1, 32'h0, 17);
        issue(1, RW_READ, 32'h20, 0, 0);
        for (int i = 0; i < 40 && !bus.m1_ack; i++) @(negedge clk);
        check("timeout_ack_seen", bus.m1_ack, 1'b1);
        @(negedge clk);
        check("timeout_busy_fall", bus.busy, 1'b0);
        check("timeout_ack_drop",  bus.m1_ack, 1'b0);
        wait_idle("timeout");

        // reset in the third BUS cycle of an m0 read
        @(posedge clk); #1;
        exp_mem(0, RW_READ, 32'h30, 0, 1);
        issue(0, RW_READ, 32'h30, 0, 0);
        for (int i = 0; i < 10 && !bus.mem_valid; i++) @(negedge clk);
        check("abort_mem_valid_seen", bus.mem_valid, 1'b1);
        @(posedge clk); #1;
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check_reset_state();
        @(posedge clk); #1 rst = 1'b0;
        mem_lat = 0;
        @(posedge clk); #1;
        exp_mem(1, RW_READ, 32'h10, 0, 1);
        exp_ack(1, 0, 32'hDEAD_BEEF, 2);
        issue(1, RW_READ, 32'h10, 0, 0);
        wait_idle("after_abort");

        // write then read by m0: rdata only changes at the read's ack
        mem_lat = 2;
        @(posedge clk); #1;
        exp_mem(0, RW_WRITE, 32'h40, 32'h1234_5678, 1);
        exp_mem(0, RW_READ,  32'h40, 0, 1);
        exp_ack(0, 0, 32'h0, 4);
        exp_ack(0, 0, 32'h1234_5678, 4);
        issue(0, RW_WRITE, 32'h40, 32'h1234_5678, 0);
        issue(0, RW_READ,  32'h40, 0, 0);
        wait_idle("write_read");

        repeat (3) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish (%0d/%0d)", n_pass, n_chk);
        $fatal(1, "watchdog");
    end

endmodule
